rc_cv_ramp: RTL and testbench
=============================

// Module: rc_cv_ramp
// PURPOSE
//  Generates the 555 VCO control voltage: a discrete model of an RC network charging toward V_HIGH
//  while trigger_in=1 and discharging toward V_LOW while trigger_in=0.
//  One exponential step per audio sample: v += (target - v) * K / 65536, computed with a serial multiplier.
//  Sits directly upstream of astable_555_vco. v_control uses the same scale (16384 = VCC).
// PARAMETERS
//  V_LOW        0      discharge target and reset level (signed 16b, 0..32766)
//  V_HIGH       16384  charge target (signed 16b, V_LOW < V_HIGH <= 32766)
//  K_CHARGE     2048   per-sample charge coefficient, 65536*(1-exp(-1/(Fs*R*C))); legal range 1..65535
//  K_DISCHARGE  2048   per-sample discharge coefficient; used only with RC_CV_DUAL_TAU_EN
// PORTS
//  clk           in   1   system clock
//  I_RSTn        in   1   asynchronous reset, active-low
//  audio_clk_en  in   1   one-clk sample strobe; minimum period is 18 clks
//  trigger_in    in   1   asynchronous digital sound trigger (1 = charge, 0 = discharge)
//  v_control     out  16  signed control voltage; feeds v_control of astable_555_vco
//  busy          out  1   step computation in progress
//  overrun       out  1   sticky: a strobe arrived while busy
// BEHAVIOUR
//  - Reset (async): v_control=V_LOW, busy=0, overrun=0, FSM=IDLE, sync flops=0, multiplier regs=0.
//  - trigger_in is passed through a 2-flop synchronizer (trig_s). Raw trigger_in is never used.
//  - FSM has three states: IDLE, MUL, UPDATE.
//  - IDLE: at edge N, if audio_clk_en=1:
//    - target = trig_s ? V_HIGH : V_LOW.
//    - diff = target - v_control (18b signed). Latch |diff| (17b) and the sign of diff.
//    - Select K (see CONFIGURATION). Clear the 33b accumulator and the bit counter.
//    - Set busy=1 and go to MUL.
//  - MUL: shift-add, one K bit per clk, LSB first. 16 clks (edges N+1..N+16), then go to UPDATE.
//  - UPDATE (edge N+17):
//    - step = acc[32:16], i.e. truncation toward zero.
//    - If step==0 and diff!=0, step=1 (min-step rule; guarantees exact convergence to target).
//    - v_next = v_control +/- step, by the sign of diff.
//    - Clamp v_next to [V_LOW, V_HIGH], register it to v_control, set busy=0, go to IDLE.
//  - Latency: strobe at edge N -> v_control changes at edge N+17. The next strobe is accepted from edge N+18.
//  - A strobe while state!=IDLE is dropped and sets overrun=1. overrun clears only on reset.
//  - diff==0: step=0 and v_control holds. busy still pulses for 17 clks.
//  - trigger_in toggling mid-computation has no effect on the step in flight.
//    The new target applies from the next accepted strobe.
//  - Reset mid-MUL aborts immediately to the reset values. No partial update is written.
//  - v_control only ever changes at an UPDATE edge and always stays in [V_LOW, V_HIGH].
// CONFIGURATION
//  RC_CV_DUAL_TAU_EN defined:
//   - K = trig_s ? K_CHARGE : K_DISCHARGE, selected at IDLE acceptance.
//   - Models separate charge and discharge resistors.
//  RC_CV_DUAL_TAU_EN undefined:
//   - K = K_CHARGE for both directions. K_DISCHARGE is ignored and its logic is not synthesized.
// TESTING
//  Defaults except K_CHARGE=32768, K_DISCHARGE=16384. Strobes spaced 1041 clks apart.
//  1 Reset: hold I_RSTn=0 -> v_control=0, busy=0, overrun=0.
//    Release with no strobe -> v_control holds 0.
//  2 Charge: trigger_in=1, 3 strobes -> v_control=8192, then 12288, then 14336.
//    Each update lands 17 clks after its strobe; busy is high for exactly those 17 clks.
//  3 Convergence: keep strobing -> v_control reaches exactly 16384 (min-step rule from 16383).
//    Further strobes leave it at 16384 and never exceed it.
//  4 Discharge from 16384 with trigger_in=0 ->
//    - with RC_CV_DUAL_TAU_EN: 12288, then 9216;
//    - without it: 8192, then 4096.
//  5 Overrun: strobes at edges N and N+5 -> exactly one update (at N+17) and overrun=1.
//    overrun stays 1 until reset.
//  6 Reset mid-op: I_RSTn low at N+8 of a charge step -> v_control=0 and busy=0 immediately.
//    After release, next strobe -> 8192.

Source files
------------

// File: rtl/rc_cv_ramp.sv
// RC control-voltage ramp: one exponential step toward V_HIGH/V_LOW per audio strobe, serial multiply.
// Build option RC_CV_DUAL_TAU_EN selects K_DISCHARGE when discharging (else K_CHARGE for both).
module rc_cv_ramp #(
  parameter logic signed [15:0] V_LOW       = 16'sd0,
  parameter logic signed [15:0] V_HIGH      = 16'sd16384,
  parameter logic        [15:0] K_CHARGE    = 16'd2048,
  parameter logic        [15:0] K_DISCHARGE = 16'd2048
) (
  input  logic               clk,
  input  logic               I_RSTn,
  input  logic               audio_clk_en,
  input  logic               trigger_in,
  output logic signed [15:0] v_control,
  output logic               busy,
  output logic               overrun
);

  // state  | meaning
  // IDLE   | waiting for a strobe; operands latched on acceptance
  // MUL    | 16 shift-add cycles of |diff| * K, LSB of K first
  // UPDATE | apply truncated step (min 1), clamp, write v_control
  typedef enum logic [1:0] {IDLE, MUL, UPDATE} state_t;

  localparam logic signed [17:0] LO_X = {{2{V_LOW[15]}}, V_LOW};
  localparam logic signed [17:0] HI_X = {{2{V_HIGH[15]}}, V_HIGH};

  if (V_LOW < 16'sd0 || V_HIGH <= V_LOW || V_HIGH > 16'sd32766 ||
      K_CHARGE == 16'd0 || K_DISCHARGE == 16'd0) begin : g_param_err
    $error("rc_cv_ramp: illegal parameter set");
  end

  state_t             state_q, state_d;
  logic               trig_m_q, trig_s_q;
  logic signed [15:0] v_q, v_d;
  logic        [16:0] mag_q, mag_d;
  logic               neg_q, neg_d;
  logic        [15:0] k_q, k_d;
  logic        [32:0] mcand_q, mcand_d;
  logic        [32:0] acc_q, acc_d;
  logic        [3:0]  cnt_q, cnt_d;
  logic               ovr_q, ovr_d;

  logic signed [15:0] target;
  logic signed [17:0] diff;
  logic        [16:0] diff_abs;
  logic        [15:0] k_sel;
  logic        [16:0] step;
  logic signed [17:0] v_sum;
  logic signed [15:0] v_clamped;

  assign target   = trig_s_q ? V_HIGH : V_LOW;
  assign diff     = {{2{target[15]}}, target} - {{2{v_q[15]}}, v_q};
  // |diff| never exceeds 32766, so the low 17 bits hold the magnitude exactly
  assign diff_abs = diff[17] ? (~diff[16:0] + 17'd1) : diff[16:0];

`ifdef RC_CV_DUAL_TAU_EN
  assign k_sel = trig_s_q ? K_CHARGE : K_DISCHARGE;
`else
  assign k_sel = K_CHARGE;
`endif

  assign step  = (acc_q[32:16] == 17'd0 && mag_q != 17'd0) ? 17'd1 : acc_q[32:16];
  assign v_sum = neg_q ? ({{2{v_q[15]}}, v_q} - {1'b0, step})
                       : ({{2{v_q[15]}}, v_q} + {1'b0, step});

  always_comb begin
    v_clamped = v_sum[15:0];
    if (v_sum < LO_X)      v_clamped = V_LOW;
    else if (v_sum > HI_X) v_clamped = V_HIGH;
  end

  always_comb begin
    state_d = state_q;
    v_d     = v_q;
    mag_d   = mag_q;
    neg_d   = neg_q;
    k_d     = k_q;
    mcand_d = mcand_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovr_d   = ovr_q | (audio_clk_en && state_q != IDLE);
    case (state_q)
      IDLE: begin
        if (audio_clk_en) begin
          mag_d   = diff_abs;
          neg_d   = diff[17];
          k_d     = k_sel;
          mcand_d = {16'd0, diff_abs};
          acc_d   = '0;
          cnt_d   = '0;
          state_d = MUL;
        end
      end
      MUL: begin
        if (k_q[0]) acc_d = acc_q + mcand_q;
        k_d     = k_q >> 1;
        mcand_d = mcand_q << 1;
        cnt_d   = cnt_q + 4'd1;
        if (cnt_q == 4'd15) state_d = UPDATE;
      end
      UPDATE: begin
        v_d     = v_clamped;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge I_RSTn) begin
    if (!I_RSTn) begin
      state_q  <= IDLE;
      trig_m_q <= 1'b0;
      trig_s_q <= 1'b0;
      v_q      <= V_LOW;
      mag_q    <= '0;
      neg_q    <= 1'b0;
      k_q      <= '0;
      mcand_q  <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      ovr_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      trig_m_q <= trigger_in;
      trig_s_q <= trig_m_q;
      v_q      <= v_d;
      mag_q    <= mag_d;
      neg_q    <= neg_d;
      k_q      <= k_d;
      mcand_q  <= mcand_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      ovr_q    <= ovr_d;
    end
  end

  assign v_control = v_q;
  assign busy      = (state_q != IDLE);
  assign overrun   = ovr_q;

endmodule

// File: tb/tb_rc_cv_ramp.sv
// Self-checking bench for rc_cv_ramp: directed ramp scenarios plus randomized steps vs an arithmetic model.
module tb_rc_cv_ramp;

  localparam int KC = 32768;
  localparam int KD = 16384;
  localparam int VH = 16384;
  localparam int GAP = 1041;

  logic               clk = 1'b0;
  logic               I_RSTn = 1'b0;
  logic               audio_clk_en = 1'b0;
  logic               trigger_in = 1'b0;
  logic signed [15:0] v_control;
  logic               busy;
  logic               overrun;

  int checks = 0;
  int failures = 0;
  int cur_v = 0;
  bit exp_ovr = 1'b0;

  rc_cv_ramp #(
    .V_LOW(16'sd0), .V_HIGH(16'sd16384), .K_CHARGE(16'd32768), .K_DISCHARGE(16'd16384)
  ) dut (
    .clk(clk), .I_RSTn(I_RSTn), .audio_clk_en(audio_clk_en), .trigger_in(trigger_in),
    .v_control(v_control), .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input int obs, input int expected);
    checks++;
    if (obs !== expected) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, expected);
    end
  endtask

  // RC step from the rules: move by floor(|target-v|*K/65536), at least 1 if not yet at target
  function automatic int model_next(input int v, input bit chg);
    int     target, d;
    longint k, mag, stp;
    target = chg ? VH : 0;
`ifdef RC_CV_DUAL_TAU_EN
    k = chg ? KC : KD;
`else
    k = KC;
`endif
    d   = target - v;
    mag = (d < 0) ? -d : d;
    stp = (mag * k) / 65536;
    if (stp == 0 && d != 0) stp = 1;
    v = (d < 0) ? v - int'(stp) : v + int'(stp);
    if (v < 0)  v = 0;
    if (v > VH) v = VH;
    return v;
  endfunction

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One accepted strobe; optional dropped strobe at edge N+drop_at and trigger flip at N+flip_at
  task automatic run_step(input string tag, input int drop_at, input int flip_at);
    int exp_v, busy_cnt;
    bit moved;
    exp_v = model_next(cur_v, trigger_in);
    @(negedge clk) audio_clk_en = 1'b1;
    @(negedge clk) audio_clk_en = 1'b0;
    busy_cnt = 0;
    moved    = 1'b0;
    for (int c = 0; c < 17; c++) begin
      if (busy) busy_cnt++;
      if (int'(v_control) != cur_v) moved = 1'b1;
      audio_clk_en = (c + 1 == drop_at);
      if (c + 1 == flip_at) trigger_in = ~trigger_in;
      @(negedge clk);
    end
    audio_clk_en = 1'b0;
    if (drop_at > 0) exp_ovr = 1'b1;
    chk_eq({tag, "_v"}, int'(v_control), exp_v);
    chk_eq({tag, "_busy_len"}, busy_cnt, 17);
    chk_eq({tag, "_early_move"}, int'(moved), 0);
    chk_eq({tag, "_busy_end"}, int'(busy), 0);
    chk_eq({tag, "_ovr"}, int'(overrun), int'(exp_ovr));
    cur_v = exp_v;
  endtask

  initial begin
    int drop, flip;

    I_RSTn = 1'b0;
    wait_clks(3);
    chk_eq("rst_v", int'(v_control), 0);
    chk_eq("rst_busy", int'(busy), 0);
    chk_eq("rst_ovr", int'(overrun), 0);
    I_RSTn = 1'b1;
    wait_clks(20);
    chk_eq("rst_hold", int'(v_control), 0);

    trigger_in = 1'b1;
    wait_clks(GAP);
    run_step("chg1", -1, -1);
    chk_eq("chg1_const", int'(v_control), 8192);
    wait_clks(GAP - 18);
    run_step("chg2", -1, -1);
    chk_eq("chg2_const", int'(v_control), 12288);
    wait_clks(GAP - 18);
    run_step("chg3", -1, -1);
    chk_eq("chg3_const", int'(v_control), 14336);

    for (int i = 0; i < 14; i++) begin
      wait_clks(GAP - 18);
      run_step("conv", -1, -1);
    end
    chk_eq("conv_final", int'(v_control), VH);

    trigger_in = 1'b0;
    wait_clks(GAP - 18);
    run_step("dis1", -1, -1);
`ifdef RC_CV_DUAL_TAU_EN
    chk_eq("dis1_const", int'(v_control), 12288);
`else
    chk_eq("dis1_const", int'(v_control), 8192);
`endif
    wait_clks(GAP - 18);
    run_step("dis2", -1, -1);
`ifdef RC_CV_DUAL_TAU_EN
    chk_eq("dis2_const", int'(v_control), 9216);
`else
    chk_eq("dis2_const", int'(v_control), 4096);
`endif

    wait_clks(GAP - 18);
    run_step("ovr", 5, -1);
    wait_clks(100);
    chk_eq("ovr_sticky", int'(overrun), 1);

    trigger_in = 1'b1;
    wait_clks(GAP);
    @(negedge clk) audio_clk_en = 1'b1;
    @(negedge clk) audio_clk_en = 1'b0;
    wait_clks(7);
    I_RSTn = 1'b0;
    #1;
    chk_eq("midrst_v", int'(v_control), 0);
    chk_eq("midrst_busy", int'(busy), 0);
    chk_eq("midrst_ovr", int'(overrun), 0);
    cur_v   = 0;
    exp_ovr = 1'b0;
    wait_clks(3);
    I_RSTn = 1'b1;
    wait_clks(5);
    run_step("after_rst", -1, -1);
    chk_eq("after_rst_const", int'(v_control), 8192);

    for (int i = 0; i < 150; i++) begin
      trigger_in = 1'($urandom_range(0, 1));
      wait_clks(3);
      drop = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 17)) : -1;
      flip = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 16)) : -1;
      run_step("rnd", drop, flip);
      wait_clks(int'($urandom_range(0, 20)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
